// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
//   IF/ID pipeline buffer. Pairs the synchronous instruction-memory read data
//   with the registered PC+1 from fetch and presents them to decode through a
//   2-entry skid buffer (head = entry 0, tail = entry 1). FIFO order is always
//   preserved. A synchronous flush empties the buffer and counts the entries
//   it discards in a saturating statistics counter.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid        fetch beat present (im_dataout + pc_plus_one valid)
//   in_ready        buffer can accept a beat (registered, != FULL)
//   im_dataout      instruction word from instruction memory
//   pc_plus_one     PC+1 aligned with im_dataout
//   flush           discard all buffered and incoming beats
//   id_valid        head entry valid toward decode (registered)
//   id_ready        decode consumes head this cycle
//   id_instr        head instruction (NOP_INSTR while !id_valid)
//   id_pc_plus_one  head PC+1 (0 while !id_valid)
//   drop_cnt        saturating count of entries discarded by flush
// ----------------------------------------------------------------------------
module if_id_buffer #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        PC_W      = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0,
    parameter int unsigned        CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] im_dataout,
    input  logic [PC_W-1:0]   pc_plus_one,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [PC_W-1:0]   id_pc_plus_one,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                id_valid_q;
    logic [DATA_W-1:0]   head_instr_q;
    logic [PC_W-1:0]     head_pc_q;
    logic [DATA_W-1:0]   tail_instr_q;
    logic [PC_W-1:0]     tail_pc_q;
    logic [CNT_W-1:0]    drop_cnt_q;
    logic [CNT_W-1:0]    drop_cnt_d;

    logic                accept;
    logic                take;
    logic [1:0]          stored;
    logic [CNT_W:0]      drop_sum;

    assign accept = in_valid & in_ready_q;
    assign take   = id_valid_q & id_ready;

    // Number of entries currently held; this is what a flush discards.
    always_comb begin
        stored = 2'd0;
        case (state_q)
            S_ONE:   stored = 2'd1;
            S_FULL:  stored = 2'd2;
            default: stored = 2'd0;
        endcase
    end

    // Add in CNT_W+1 bits; a set carry bit means the true count exceeds
    // the maximum, so clamp rather than wrap.
    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + {{(CNT_W-1){1'b0}}, stored};
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    // Head registers are reloaded with NOP/0 whenever the buffer empties so
    // the outputs stay direct register values with no muxing on id_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            in_ready_q   <= 1'b1;
            id_valid_q   <= 1'b0;
            head_instr_q <= NOP_INSTR;
            head_pc_q    <= '0;
            tail_instr_q <= NOP_INSTR;
            tail_pc_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            if (flush) begin
                state_q      <= S_EMPTY;
                in_ready_q   <= 1'b1;
                id_valid_q   <= 1'b0;
                head_instr_q <= NOP_INSTR;
                head_pc_q    <= '0;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        if (accept) begin
                            state_q      <= S_ONE;
                            id_valid_q   <= 1'b1;
                            head_instr_q <= im_dataout;
                            head_pc_q    <= pc_plus_one;
                        end
                    end
                    S_ONE: begin
                        if (accept && !take) begin
                            state_q      <= S_FULL;
                            in_ready_q   <= 1'b0;
                            tail_instr_q <= im_dataout;
                            tail_pc_q    <= pc_plus_one;
                        end else if (take && !accept) begin
                            state_q      <= S_EMPTY;
                            id_valid_q   <= 1'b0;
                            head_instr_q <= NOP_INSTR;
                            head_pc_q    <= '0;
                        end else if (accept && take) begin
                            head_instr_q <= im_dataout;
                            head_pc_q    <= pc_plus_one;
                        end
                    end
                    S_FULL: begin
                        if (take) begin
                            state_q      <= S_ONE;
                            in_ready_q   <= 1'b1;
                            head_instr_q <= tail_instr_q;
                            head_pc_q    <= tail_pc_q;
                        end
                    end
                    default: begin
                        state_q      <= S_EMPTY;
                        in_ready_q   <= 1'b1;
                        id_valid_q   <= 1'b0;
                        head_instr_q <= NOP_INSTR;
                        head_pc_q    <= '0;
                    end
                endcase
            end
        end
    end

    assign in_ready       = in_ready_q;
    assign id_valid       = id_valid_q;
    assign id_instr       = head_instr_q;
    assign id_pc_plus_one = head_pc_q;
    assign drop_cnt       = drop_cnt_q;

endmodule
